prco_regfile_sb: RTL

//  Second-generation PRCO register file. Parametrised width and depth, two

---
 rtl/prco_regfile_sb_pkg.sv | 17 +
 rtl/prco_regfile_sb_if.sv | 40 ++++
 rtl/prco_scoreboard.sv | 47 ++++
 rtl/prco_regfile_sb.sv | 96 +++++++++
 4 files changed

// File: rtl/prco_regfile_sb_pkg.sv
// Shared constants for the PRCO register file: default geometry, the stack
// register indices and their reset value.
package prco_regfile_sb_pkg;

  localparam int          PRCO_DW     = 16;
  localparam int          PRCO_NREGS  = 8;
  localparam int          PRCO_AW     = 3;
  localparam int          REG_SP      = 7;
  localparam int          REG_BP      = 6;
  localparam logic [15:0] PRCO_SP_RST = 16'h00FF;

  // SP and BP come out of reset pointing at the top of the boot stack.
  function automatic logic is_stack_reg(input int idx);
    return (idx == REG_SP) || (idx == REG_BP);
  endfunction

endpackage

// File: rtl/prco_regfile_sb_if.sv
// Decode/writeback bus of the register file: read selects, both write
// ports, the load lock and the stall/collision status coming back.
interface prco_regfile_sb_if #(
  parameter int P_DW = 16,
  parameter int P_AW = 3
);

  logic            i_en;
  logic [P_AW-1:0] i_sela;
  logic [P_DW-1:0] q_data;
  logic [P_AW-1:0] i_selb;
  logic [P_DW-1:0] q_datb;
  logic            i_we;
  logic [P_AW-1:0] i_seld;
  logic [P_DW-1:0] i_datd;
  logic            i_wem;
  logic [P_AW-1:0] i_selm;
  logic [P_DW-1:0] i_datm;
  logic            i_lock;
  logic [P_AW-1:0] i_selk;
  logic            q_stall;
  logic            q_wcollide;

  modport master (
    output i_en, i_sela, i_selb,
    output i_we, i_seld, i_datd,
    output i_wem, i_selm, i_datm,
    output i_lock, i_selk,
    input  q_data, q_datb, q_stall, q_wcollide
  );

  modport slave (
    input  i_en, i_sela, i_selb,
    input  i_we, i_seld, i_datd,
    input  i_wem, i_selm, i_datm,
    input  i_lock, i_selk,
    output q_data, q_datb, q_stall, q_wcollide
  );

endinterface

// File: rtl/prco_scoreboard.sv
// Load-use scoreboard: one busy bit per register, set by a load lock and
// cleared by the matching load return; drives the decode stall.
module prco_scoreboard #(
  parameter int P_NREGS = 8,
  parameter int P_AW    = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_en,
  input  logic            i_lock,
  input  logic [P_AW-1:0] i_selk,
  input  logic            i_wem,
  input  logic [P_AW-1:0] i_selm,
  input  logic [P_AW-1:0] i_sela,
  input  logic [P_AW-1:0] i_selb,
  output logic            q_stall
);

  logic [P_NREGS-1:0] busy_reg;
  logic [P_NREGS-1:0] busy_next;
  logic [P_NREGS-1:0] lock_hit;
  logic [P_NREGS-1:0] clear_hit;

  // Lock is applied after clear so a re-issued load on the returning
  // register keeps it busy.
  for (genvar gi = 0; gi < P_NREGS; gi++) begin : g_busy
    assign lock_hit[gi]  = i_lock & (i_selk == P_AW'(gi));
    assign clear_hit[gi] = i_wem  & (i_selm == P_AW'(gi));
    assign busy_next[gi] = lock_hit[gi] | (busy_reg[gi] & ~clear_hit[gi]);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      busy_reg <= '0;
    end else if (i_en) begin
      busy_reg <= busy_next;
    end
  end

  // A load landing this cycle is forwarded by the read bypass, so it
  // releases the stall immediately.
  always_comb begin
    q_stall = (busy_reg[i_sela] & ~clear_hit[i_sela])
            | (busy_reg[i_selb] & ~clear_hit[i_selb]);
  end

endmodule

// File: rtl/prco_regfile_sb.sv
// PRCO register file: two registered write-first read ports, ALU (D) and
// load (M) write ports with M priority, and a load-use scoreboard.
module prco_regfile_sb
  import prco_regfile_sb_pkg::*;
#(
  parameter int              P_DW     = PRCO_DW,
  parameter int              P_NREGS  = PRCO_NREGS,
  parameter int              P_AW     = PRCO_AW,
  parameter logic [P_DW-1:0] P_SP_RST = P_DW'(PRCO_SP_RST)
) (
  input logic              i_clk,
  input logic              i_reset,
  prco_regfile_sb_if.slave bus
);

  logic [P_DW-1:0] r_regs [0:P_NREGS-1];

  logic [P_DW-1:0] data_reg;
  logic [P_DW-1:0] data_next;
  logic [P_DW-1:0] datb_reg;
  logic [P_DW-1:0] datb_next;
  logic            wcollide_reg;
  logic            wcollide_next;
  logic            stall;

  // Read bypass mirrors the array: the M check is last so it wins over D.
  always_comb begin
    data_next = r_regs[bus.i_sela];
    if (bus.i_we && (bus.i_seld == bus.i_sela)) begin
      data_next = bus.i_datd;
    end
    if (bus.i_wem && (bus.i_selm == bus.i_sela)) begin
      data_next = bus.i_datm;
    end

    datb_next = r_regs[bus.i_selb];
    if (bus.i_we && (bus.i_seld == bus.i_selb)) begin
      datb_next = bus.i_datd;
    end
    if (bus.i_wem && (bus.i_selm == bus.i_selb)) begin
      datb_next = bus.i_datm;
    end

    wcollide_next = bus.i_we & bus.i_wem & (bus.i_seld == bus.i_selm);
  end

  // M is assigned after D, so on a shared select the load data lands.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < P_NREGS; i++) begin
        r_regs[i] <= is_stack_reg(i) ? P_SP_RST : '0;
      end
    end else if (bus.i_en) begin
      if (bus.i_we) begin
        r_regs[bus.i_seld] <= bus.i_datd;
      end
      if (bus.i_wem) begin
        r_regs[bus.i_selm] <= bus.i_datm;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      data_reg     <= '0;
      datb_reg     <= '0;
      wcollide_reg <= 1'b0;
    end else if (bus.i_en) begin
      data_reg     <= data_next;
      datb_reg     <= datb_next;
      wcollide_reg <= wcollide_next;
    end
  end

  prco_scoreboard #(
    .P_NREGS (P_NREGS),
    .P_AW    (P_AW)
  ) u_scoreboard (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_en    (bus.i_en),
    .i_lock  (bus.i_lock),
    .i_selk  (bus.i_selk),
    .i_wem   (bus.i_wem),
    .i_selm  (bus.i_selm),
    .i_sela  (bus.i_sela),
    .i_selb  (bus.i_selb),
    .q_stall (stall)
  );

  assign bus.q_data     = data_reg;
  assign bus.q_datb     = datb_reg;
  assign bus.q_wcollide = wcollide_reg;
  assign bus.q_stall    = stall;

endmodule
